// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 op encodings, FSM states and fixed result constants.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic logic [XLEN-1:0] abs_val(
    input logic [XLEN-1:0] v,
    input logic            neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// One iteration of the unsigned datapath: shift-add multiply or
// restoring divide on a packed {hi, lo} 64-bit accumulator.
module muldiv_core_step
  import muldiv_pkg::*;
(
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rsh;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd};
    w_rsh  = i_acc[2*XLEN-1:XLEN-1];
    w_diff = w_rsh - {1'b0, i_opnd};
    o_acc  = i_acc;
    if (i_is_div) begin
      // Borrow out of the 33-bit subtract means the trial failed.
      if (w_diff[XLEN])
        o_acc = {w_rsh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      else
        o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_opnd;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_negq;
  logic                r_negr;
  logic [XLEN-1:0]     r_result;

  logic                w_is_div;
  logic                w_sa;
  logic                w_sb;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic                w_div0;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_spec_res;
  logic                w_accept;
  logic                w_fast;
  logic [2*XLEN-1:0]   w_step;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fix_res;

  assign w_is_div = i_op[2];
  assign w_sa = i_rs1_data[XLEN-1] &&
    (i_op == OP_MULH || i_op == OP_MULHSU ||
     i_op == OP_DIV  || i_op == OP_REM);
  assign w_sb = i_rs2_data[XLEN-1] &&
    (i_op == OP_MULH || i_op == OP_DIV || i_op == OP_REM);
  assign w_abs_a = abs_val(i_rs1_data, w_sa);
  assign w_abs_b = abs_val(i_rs2_data, w_sb);

  assign w_div0 = w_is_div && (i_rs2_data == '0);
  assign w_ovf = (i_op == OP_DIV || i_op == OP_REM) &&
    (i_rs1_data == INT_MIN) && (i_rs2_data == '1);
  assign w_special = w_div0 || w_ovf;
  // REM/REMU have op[1] set; DIV/DIVU do not.
  assign w_spec_res = w_div0 ?
    (i_op[1] ? i_rs1_data : DIV0_QUOT) :
    (i_op[1] ? '0 : INT_MIN);

  assign w_accept = (r_state == IDLE) && i_start && !i_flush;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] w_fprod;
  assign w_fast = !w_is_div;
  assign w_fprod =
    $signed({{XLEN{w_sa}}, i_rs1_data}) *
    $signed({{XLEN{w_sb}}, i_rs2_data});
`else
  assign w_fast = 1'b0;
`endif

  muldiv_core_step u_step (
    .i_is_div (r_op[2]),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step)
  );

  assign w_prod = r_negq ? -r_acc : r_acc;
  assign w_quo  = r_negq ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_negr ? -r_acc[2*XLEN-1:XLEN]
                         : r_acc[2*XLEN-1:XLEN];
  assign w_fix_res = r_op[2] ? (r_op[1] ? w_rem : w_quo) :
    (r_op == OP_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_special)   w_next = DONE;
          else if (w_fast) w_next = FIX;
          else             w_next = CALC;
        end
      end
      CALC: begin
        if (i_flush)
          w_next = IDLE;
        else if (r_cnt == CNT_W'(XLEN-1))
          w_next = FIX;
      end
      FIX:     w_next = i_flush ? IDLE : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= i_op;
        r_cnt  <= '0;
        r_negq <= w_sa ^ w_sb;
        r_negr <= w_sa;
        r_opnd <= w_is_div ? w_abs_b : w_abs_a;
        r_acc  <= {{XLEN{1'b0}}, w_is_div ? w_abs_a : w_abs_b};
        if (w_special)
          r_result <= w_spec_res;
`ifdef MULDIV_FAST_MUL_EN
        // Signed product is already final; skip sign fix-up.
        if (w_fast) begin
          r_acc  <= w_fprod;
          r_negq <= 1'b0;
        end
`endif
      end
      if (r_state == CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == FIX && !i_flush)
        r_result <= w_fix_res;
    end
  end

  assign o_busy   = (r_state == CALC) || (r_state == FIX);
  assign o_done   = (r_state == DONE);
  assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, randomized
// ops against an arithmetic model, handshake, flush and reset cases.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors;
  int checks;
  logic [31:0] exp_last;

  muldiv_unit dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_op       (op),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_flush    (flush),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b
  );
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Latency in negedge samples after the accepting posedge.
  function automatic int exp_lat(
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b
  );
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 &&
        b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 2;
`endif
    return 34;
  endfunction

  task automatic run_op(
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output int          lat,
    output int          nbusy
  );
    @(negedge clk);
    op = f3; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    nbusy = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = j;
        break;
      end
    end
    res = result;
  endtask

  task automatic check_op(
    input string name, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] want
  );
    logic [31:0] res;
    int lat;
    int nb;
    int wl;
    run_op(f3, a, b, res, lat, nb);
    wl = exp_lat(f3, a, b);
    checks++;
    if (res !== want) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, res, want);
    end
    checks++;
    if (lat != wl) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, wl);
    end
    checks++;
    if (nb != wl - 1) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d want %0d", name, nb, wl - 1);
    end
    exp_last = want;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h want 0 0 0",
               busy, done, result);
    end
    rst = 1'b0;
    exp_last = '0;
  endtask

  task automatic test_mul;
    check_op("mul_7x6", 3'd0, 32'd7, 32'd6, 32'h0000_002A);
    check_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE);
    check_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF);
    check_op("mulh_neg", 3'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
  endtask

  task automatic test_div;
    check_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    check_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    check_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);
    check_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2);
  endtask

  task automatic test_special;
    check_op("div_by0", 3'd4, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF);
    check_op("rem_by0", 3'd6, 32'h1234_5678, 32'h0, 32'h1234_5678);
    check_op("divu_by0", 3'd5, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF);
    check_op("remu_by0", 3'd7, 32'h1234_5678, 32'h0, 32'h1234_5678);
    check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000);
    check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: a = 32'($urandom_range(0, 20));
        4: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      check_op($sformatf("rand%0d_op%0d", i, f3), f3, a, b,
               ref_model(f3, a, b));
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j == 5) begin
        op = 3'd0; rs1 = 32'd7; rs2 = 32'd6; start = 1'b1;
      end
      if (j == 9) start = 1'b0;
      if (done) begin
        lat = j;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (result !== 32'd14 || lat != 34) begin
      errors++;
      $display("FAIL busy_restart: result=%h lat=%0d want 0000000e 34",
               result, lat);
    end
    exp_last = 32'd14;
  endtask

  task automatic test_start_held;
    int lat;
    int extra;
    @(negedge clk);
    op = 3'd5; rs1 = 32'd1000; rs2 = 32'd10; start = 1'b1;
    lat = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (done) begin
        lat = j;
        break;
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (result !== 32'd100 || lat != 34) begin
      errors++;
      $display("FAIL start_held result: result=%h lat=%0d want 00000064 34",
               result, lat);
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL start_held extra: got %0d active cycles want 0",
               extra);
    end
    exp_last = 32'd100;
  endtask

  task automatic test_flush;
    int act;
    @(negedge clk);
    op = 3'd3; rs1 = $urandom; rs2 = $urandom; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 1; j < 10; j++) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b done=%b want 0 0", busy, done);
    end
    act = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) act++;
    end
    checks++;
    if (act != 0 || result !== exp_last) begin
      errors++;
      $display("FAIL flush_quiet: active=%0d result=%h want 0 %h",
               act, result, exp_last);
    end
    op = 3'd5; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    act = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) act++;
    end
    checks++;
    if (act != 0 || result !== exp_last) begin
      errors++;
      $display("FAIL flush_with_start: active=%0d result=%h want 0 %h",
               act, result, exp_last);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    op = 3'd7; rs1 = 32'hDEAD_BEEF; rs2 = 32'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 1; j <= 20; j++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h want 0 0 0",
               busy, done, result);
    end
    exp_last = '0;
    check_op("after_reset", 3'd5, 32'd100, 32'd7, 32'd14);
  endtask

  task automatic test_back_to_back;
    check_op("b2b_mul", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    check_op("b2b_div", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    check_op("b2b_rem", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op = '0;
    rs1 = '0;
    rs2 = '0;
    exp_last = '0;
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_start_while_busy;
    test_start_held;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
